serial_mul_pipe: RTL and testbench

//  Parametrised bit-serial unsigned/signed multiplier with a valid/ready handshake.

---
 rtl/serial_mul_pipe_if.sv | 24 ++
 rtl/serial_mul_pipe.sv | 135 +++++++++++++
 tb/tb_serial_mul_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_mul_pipe_if.sv
// Operand/product handshake bundle for serial_mul_pipe.
// master: operand source (drives in_valid/a/b); slave: the multiplier.
interface serial_mul_pipe_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned BW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     a;
  logic [BW-1:0]     b;
  logic              out_valid;
  logic [AW+BW-1:0]  q;
  logic              busy;

  modport master (
    output in_valid, a, b,
    input  in_ready, out_valid, q, busy
  );

  modport slave (
    input  in_valid, a, b,
    output in_ready, out_valid, q, busy
  );
endinterface

// File: rtl/serial_mul_pipe.sv
// Bit-serial multiplier: a is streamed LSB first through a chain of BW
// serial multiply-add cells against a parallel b, and the product bits are
// collected back into a parallel word. One product per PW+3 cycles.
// Optional build macro SERIAL_MUL_SIGNED_EN selects two's complement operands.
module serial_mul_pipe #(
  parameter int unsigned AW = 8,
  parameter int unsigned BW = 8
) (
  input logic               clk,
  input logic               rst,
  serial_mul_pipe_if.slave  bus
);

  localparam int unsigned PW = AW + BW;
  localparam int unsigned CW = $clog2(PW + 2);

  // Last counter value of RUN, and last value at which a product bit is collected.
  localparam logic [CW-1:0] CntLast = CW'(PW + 1);
  localparam logic [CW-1:0] CntCap  = CW'(PW);

`ifdef SERIAL_MUL_SIGNED_EN
  // The b-MSB cell subtracts: inverted partial product plus a preset carry.
  localparam logic [BW-1:0] CarryInit = {1'b1, {(BW-1){1'b0}}};
`else
  localparam logic [BW-1:0] CarryInit = '0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   sh_q, sh_d;     // parallel-to-serial shifter for a
  logic [BW-1:0]   b_q, b_d;
  logic [BW-1:0]   s_q, s_d;       // per-cell sum registers
  logic [BW-1:0]   c_q, c_d;       // per-cell carry registers
  logic [PW-1:0]   sp_q, sp_d;     // serial-to-parallel product collector
  logic [PW-1:0]   q_q, q_d;

  logic            in_ready;
  logic            accept;
  logic [PW-1:0]   a_ext;
  logic [BW-1:0]   pp, s_in, cell_sum, cell_carry;

`ifdef SERIAL_MUL_SIGNED_EN
  assign a_ext = {{BW{bus.a[AW-1]}}, bus.a};
`else
  assign a_ext = {{BW{1'b0}}, bus.a};
`endif

  assign in_ready = (state_q != StRun);
  assign accept   = bus.in_valid & in_ready;

  // Serial cell chain: head (cell BW-1) takes sum_in = 0, cell 0 emits product bits.
  always_comb begin
    pp = {BW{sh_q[0]}} & b_q;
`ifdef SERIAL_MUL_SIGNED_EN
    pp[BW-1] = ~pp[BW-1];
`endif
    s_in       = {1'b0, s_q[BW-1:1]};
    cell_sum   = pp ^ s_in ^ c_q;
    cell_carry = (pp & s_in) | (pp & c_q) | (s_in & c_q);
  end

  // Next-state, datapath control and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    sp_d    = sp_q;
    q_d     = q_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        sh_d = sh_q >> 1;
        s_d  = cell_sum;
        c_d  = cell_carry;
        // Bit t leaves cell 0 one edge after it is computed; collect for cnt 1..PW.
        if (cnt_q != '0 && cnt_q <= CntCap) begin
          sp_d = {s_q[0], sp_q[PW-1:1]};
        end
        if (cnt_q == CntLast) begin
          state_d = StDone;
          q_d     = sp_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Accepting in DONE goes straight to RUN, giving back-to-back words.
    if (accept) begin
      state_d = StRun;
      cnt_d   = '0;
      sh_d    = a_ext;
      b_d     = bus.b;
      s_d     = '0;
      c_d     = CarryInit;
    end
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      sp_q    <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sp_q    <= sp_d;
      q_q     <= q_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = ~in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.q         = q_q;

endmodule

// File: tb/tb_serial_mul_pipe.sv
// Self-checking bench for serial_mul_pipe: directed and random words checked
// against an arithmetic product model, latency, back-to-back and reset cases.
module tb_serial_mul_pipe;

  localparam int unsigned AW    = 8;
  localparam int unsigned BW    = 8;
  localparam int unsigned PW    = AW + BW;
  localparam int unsigned Lat   = PW + 2;
  localparam int unsigned Limit = PW + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_mul_pipe_if #(.AW(AW), .BW(BW)) bus ();

  serial_mul_pipe #(.AW(AW), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] x, input logic [BW-1:0] y);
    longint p;
`ifdef SERIAL_MUL_SIGNED_EN
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
`else
    longint sx = longint'({1'b0, x});
    longint sy = longint'({1'b0, y});
`endif
    p = sx * sy;
    return p[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge until out_valid is seen; 0 if the bound expires.
  task automatic wait_out(output int unsigned edges);
    int unsigned n = 0;
    edges = 0;
    while (n < Limit) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  // One isolated word: operands scrambled after accept to show they are not resampled.
  task automatic run_word(input logic [AW-1:0] x, input logic [BW-1:0] y, input string tag);
    int unsigned  edges;
    logic [PW-1:0] exp = ref_mul(x, y);
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = AW'($urandom);
    bus.b = BW'($urandom);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_out(edges);
    check({tag, "_lat"}, 64'(edges), 64'(Lat));
    check({tag, "_q"}, 64'(bus.q), 64'(exp));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_hold"}, 64'(bus.q), 64'(exp));
  endtask

  initial begin
    int unsigned edges;
    int          pulses;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_q", 64'(bus.q), 64'd0);

    // Directed words, including the extremes.
    run_word(8'd3, 8'd5, "w3x5");
    run_word(8'd255, 8'd255, "wffxff");
    run_word(8'd0, 8'hA5, "w0xa5");
    run_word(8'h80, 8'h7F, "w80x7f");
    run_word(8'h7F, 8'h7F, "w7fx7f");
    run_word(8'h80, 8'h80, "w80x80");

    // Back-to-back: in_valid held through RUN; second accept happens in the DONE cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd9;
    @(posedge clk);
    #1;
    bus.a = 8'd200;
    bus.b = 8'd100;
    wait_out(edges);
    check("b2b_lat0", 64'(edges), 64'(Lat));
    check("b2b_q0", 64'(bus.q), 64'(ref_mul(8'd7, 8'd9)));
    check("b2b_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_out(edges);
    check("b2b_lat1", 64'(edges), 64'(Lat));
    check("b2b_q1", 64'(bus.q), 64'(ref_mul(8'd200, 8'd100)));

    // Random words.
    for (int i = 0; i < 20; i++) begin
      ra = AW'($urandom);
      rb = BW'($urandom);
      run_word(ra, rb, "rnd");
    end

    // Reset mid-RUN with a pending request: word aborted, nothing emitted.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'd11;
    bus.b = 8'd13;
    @(posedge clk);
    #1;
    bus.a = 8'd1;
    bus.b = 8'd1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ign_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_q", 64'(bus.q), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd1);
    pulses = 0;
    for (int i = 0; i < int'(Lat) + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    check("abort_nopulse", 64'(pulses), 64'd0);

    // Recovery after abort.
    run_word(8'd3, 8'd5, "post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
